// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/control bus between the multiply/divide sequencer and
// one ALU instance.
//   src1, src2 : ALU operands (driven by the sequencer)
//   ctrl       : ALU control, 0010 = ADD, 0110 = SUB, 0000 = idle
//   result     : ALU registered result, valid the cycle after an issue
// modport master: the sequencer side; modport slave: the ALU side.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] result;

    modport master (
        output src1,
        output src2,
        output ctrl,
        input  result
    );

    modport slave (
        input  src1,
        input  src2,
        input  ctrl,
        output result
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: iterative unsigned MUL (low 32 bits) / restoring DIV sequencer that
// builds its arithmetic out of ADD/SUB operations issued to an external ALU.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start, op     : command strobe (taken only when ready=1); op 0=MUL, 1=DIV
//   a, b          : multiplicand/dividend, multiplier/divisor
//   ready         : high while idle
//   done          : one-cycle pulse; res_lo/res_hi/err valid from this cycle on
//   err           : DIV with b==0 or b[31]==1
//   res_lo/res_hi : product/0 (MUL) or quotient/remainder (DIV)
//   alu           : ALU operand/control bus (master side)
//
// Build option: define ALU_SEQ_EARLY_EXIT_EN to let MUL finish as soon as no
// set multiplier bits remain (checked in the ITER state).
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi,
    alu_seq_if.master        alu
);

    localparam logic [3:0]       CTRL_IDLE = 4'b0000;
    localparam logic [3:0]       CTRL_ADD  = 4'b0010;
    localparam logic [3:0]       CTRL_SUB  = 4'b0110;
    localparam logic [CNT_W-1:0] K_LAST    = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ITER,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] k, k_nxt;
    logic             op_q, op_nxt;
    logic [WIDTH-1:0] dvsr, dvsr_nxt;     // DIV divisor
    logic [WIDTH-1:0] acc, acc_nxt;       // MUL partial product
    logic [WIDTH-1:0] mcand, mcand_nxt;   // MUL shifted multiplicand
    logic [WIDTH-1:0] mplr, mplr_nxt;     // MUL multiplier, shifted right so bit 0 is bit k
    logic [WIDTH-1:0] rem, rem_nxt;       // DIV partial remainder
    logic [WIDTH-1:0] q, q_nxt;           // DIV dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] trial, trial_nxt;   // DIV {rem, next dividend bit}
    logic [WIDTH-1:0] res_lo_nxt, res_hi_nxt;
    logic             err_nxt;
    logic             last;
    logic             fin;                // normal completion, results taken from datapath
    logic             early_exit;

    assign ready = (state == S_IDLE);
    assign done  = (state == S_DONE);
    assign last  = (k == K_LAST);

`ifdef ALU_SEQ_EARLY_EXIT_EN
    // mplr has already been shifted down by k, so this is mplr[31:k]==0.
    assign early_exit = (mplr == '0);
`else
    assign early_exit = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        op_nxt     = op_q;
        dvsr_nxt   = dvsr;
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplr_nxt   = mplr;
        rem_nxt    = rem;
        q_nxt      = q;
        trial_nxt  = trial;
        res_lo_nxt = res_lo;
        res_hi_nxt = res_hi;
        err_nxt    = err;
        fin        = 1'b0;
        alu.src1   = '0;
        alu.src2   = '0;
        alu.ctrl   = CTRL_IDLE;

        case (state)
            S_IDLE: begin
                if (start) begin
                    op_nxt    = op;
                    k_nxt     = '0;
                    acc_nxt   = '0;
                    rem_nxt   = '0;
                    trial_nxt = '0;
                    if (!op) begin
                        mcand_nxt = a;
                        mplr_nxt  = b;
                        q_nxt     = '0;
                        dvsr_nxt  = '0;
                        // A set bit skips the ITER cycle and goes straight to the add.
                        state_nxt = b[0] ? S_ISSUE : S_ITER;
                    end else begin
                        mcand_nxt = '0;
                        mplr_nxt  = '0;
                        q_nxt     = a;
                        dvsr_nxt  = b;
                        // b[31] set would let the trial subtraction overflow.
                        if (b == '0 || b[WIDTH-1]) begin
                            state_nxt  = S_DONE;
                            res_lo_nxt = '1;
                            res_hi_nxt = a;
                            err_nxt    = 1'b1;
                        end else begin
                            state_nxt = S_ITER;
                        end
                    end
                end
            end

            S_ITER: begin
                if (!op_q) begin
                    // Only reached for a clear multiplier bit.
                    if (early_exit) begin
                        state_nxt = S_DONE;
                        fin       = 1'b1;
                    end else begin
                        mcand_nxt = mcand << 1;
                        mplr_nxt  = mplr >> 1;
                        if (last) begin
                            state_nxt = S_DONE;
                            fin       = 1'b1;
                        end else begin
                            k_nxt     = k + CNT_W'(1);
                            state_nxt = mplr[1] ? S_ISSUE : S_ITER;
                        end
                    end
                end else begin
                    trial_nxt = {rem[WIDTH-2:0], q[WIDTH-1]};
                    q_nxt     = q << 1;
                    state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (!op_q) begin
                    alu.src1 = acc;
                    alu.src2 = mcand;
                    alu.ctrl = CTRL_ADD;
                end else begin
                    alu.src1 = trial;
                    alu.src2 = dvsr;
                    alu.ctrl = CTRL_SUB;
                end
                state_nxt = S_CAPTURE;
            end

            S_CAPTURE: begin
                if (!op_q) begin
                    acc_nxt   = alu.result;
                    mcand_nxt = mcand << 1;
                    mplr_nxt  = mplr >> 1;
                end else begin
                    // Negative difference means the divisor did not fit: restore.
                    rem_nxt = alu.result[WIDTH-1] ? trial : alu.result;
                    q_nxt   = {q[WIDTH-1:1], ~alu.result[WIDTH-1]};
                end
                if (last) begin
                    state_nxt = S_DONE;
                    fin       = 1'b1;
                end else begin
                    k_nxt = k + CNT_W'(1);
                    if (!op_q) state_nxt = mplr[1] ? S_ISSUE : S_ITER;
                    else       state_nxt = S_ITER;
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Results are loaded on the edge into DONE so they are valid with done.
        if (fin) begin
            res_lo_nxt = op_q ? q_nxt : acc_nxt;
            res_hi_nxt = op_q ? rem_nxt : '0;
            err_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            k      <= '0;
            op_q   <= 1'b0;
            dvsr   <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplr   <= '0;
            rem    <= '0;
            q      <= '0;
            trial  <= '0;
            res_lo <= '0;
            res_hi <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            k      <= k_nxt;
            op_q   <= op_nxt;
            dvsr   <= dvsr_nxt;
            acc    <= acc_nxt;
            mcand  <= mcand_nxt;
            mplr   <= mplr_nxt;
            rem    <= rem_nxt;
            q      <= q_nxt;
            trial  <= trial_nxt;
            res_lo <= res_lo_nxt;
            res_hi <= res_hi_nxt;
            err    <= err_nxt;
        end
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Iterative multiply/divide sequencer that acts as the initiator on the 32-bit ALU's operand/control interface.
- Drives src1/src2/4-bit ALU control and consumes the ALU's registered result one cycle later.
- Builds unsigned MUL (low 32 bits) and unsigned DIV (quotient/remainder) from repeated ADD/SUB operations.
- Sits between the decode stage (command side) and one ALU instance (execute side).

Parameters:
- WIDTH, 32: datapath width; only 32 is supported.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- start  in  1  command strobe; accepted only when ready=1.
- op  in  1  0 = MUL, 1 = DIV.
- a  in  32  multiplicand or dividend.
- b  in  32  multiplier or divisor.
- ready  out  1  high iff FSM is in IDLE.
- done  out  1  one-cycle pulse; res_lo, res_hi and err are valid from this cycle.
- err  out  1  DIV error: b==0 or b[31]==1.
- res_lo  out  32  product (MUL) or quotient (DIV).
- res_hi  out  32  0 (MUL) or remainder (DIV).
- alu_src1  out  32  ALU operand 1.
- alu_src2  out  32  ALU operand 2.
- alu_ctrl  out  4  ALU control: 0010 = ADD, 0110 = SUB, 0000 = idle.
- alu_result  in  32  ALU registered result; valid the cycle after issue.

Behaviour:
- Clocking/reset:
  - Single clock; reset is synchronous, active-high.
  - rst=1 at a posedge forces state IDLE and clears done, err, res_lo, res_hi and all internal registers to 0.
  - ready=1 from the first cycle after that edge.
  - An in-flight operation is discarded silently; no done pulse is produced.
- Idle ALU drive: alu_src1=alu_src2=0 and alu_ctrl=0000 in every state except ISSUE.
- FSM states: IDLE, ITER, ISSUE, CAPTURE, DONE.
- Command acceptance:
  - start=1 in IDLE latches a, b and op.
  - start outside IDLE is ignored; latched operands do not change.
  - Acceptance cycle = cycle 0.
- DIV error check (cycle 0): if b==0 or b[31]==1, go to DONE. Result: err=1, res_lo=FFFFFFFF, res_hi=a, done pulse in cycle 1.
- Iteration counter: k=0..31 (LSB-first for MUL), incremented when leaving an iteration. After k=31 completes, go to DONE.
- MUL (acc=0, mcand=a, mplr=b):
  - ITER with mplr[k]==0: 1 cycle; mcand<<=1.
  - ITER with mplr[k]==1: go to ISSUE. ISSUE drives ADD with src1=acc, src2=mcand. CAPTURE sets acc=alu_result and mcand<<=1.
  - Each set bit costs 2 cycles; each clear bit costs 1 cycle.
  - Result bits above 31 are discarded; cout/overflow are not used.
- DIV (restoring; rem=0, q=a):
  - ITER: trial={rem[30:0],q[31]}; q<<=1. Go to ISSUE.
  - ISSUE drives SUB with src1=trial, src2=b.
  - CAPTURE: if alu_result[31]==0 then rem=alu_result, q[0]=1; else rem=trial, q[0]=0.
  - Each iteration costs 3 cycles (ITER, ISSUE, CAPTURE).
  - Correctness relies on b<2^31, so the signed difference never overflows.
- DONE (1 cycle):
  - done=1; res_lo/res_hi are loaded; then return to IDLE.
  - res_lo, res_hi and err hold until the next accepted start or rst.
  - done=0 in every other cycle.
- Latency (done cycle; start accepted in cycle 0):
  - MUL: 33 + popcount(b).
  - DIV: 97.
  - DIV error: 1.
- A new start is accepted in the cycle after done, because ready=1 in IDLE.

Optional Feature:
- Macro: ALU_SEQ_EARLY_EXIT_EN
- Defined: in ITER for MUL, if mplr[31:k]==0, go to DONE. That ITER cycle is consumed.
  - b=0: done at cycle 2.
  - b=6: done at cycle 7.
- Undefined: all 32 MUL iterations always run. DIV is unaffected in both cases.

Test Plan:
- MUL a=7, b=6 -> res_lo=42, res_hi=0, err=0. Done at cycle 35 (cycle 7 with EARLY_EXIT). alu_ctrl=0010 in exactly 2 cycles.
- MUL a=FFFFFFFF, b=FFFFFFFF -> res_lo=00000001, done at cycle 65. MUL b=0 -> res_lo=0, done at 33 (2 with EARLY_EXIT).
- DIV a=100, b=7 -> res_lo=14, res_hi=2, err=0, done at 97. alu_ctrl=0110 in exactly 32 cycles. DIV a=FFFFFFFF, b=10 -> res_lo=19999999, res_hi=5.
- DIV b=0 and DIV b=80000000 (a=55) -> err=1, res_lo=FFFFFFFF, res_hi=55, done at cycle 1, alu_ctrl stays 0000.
- Start DIV, raise rst at cycle 20 for 1 cycle -> next cycle ready=1, done=0, res_lo=res_hi=0, alu_ctrl=0000. Then MUL 3*5 -> 15.
- start re-asserted with different operands during a busy MUL 7*6 -> ignored, result still 42, exactly one done pulse.
